// File: rtl/seq_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clk out.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit (PAR state) after each word.
//
// state | meaning
// IDLE  | no word in flight, seq_out at IDLE_LEVEL, ready for a word
// SHIFT | data bits on seq_out, bitCnt = index of the bit currently shown
// PAR   | parity bit on seq_out (parity build only), ready for the next word
module seq_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SEQ_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] bitCnt;
  logic [WIDTH-1:0] shiftReg;
  logic             lastBit;
  logic             accept;

  function automatic logic headBit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shiftOnce(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign lastBit = (state == SHIFT) && (bitCnt == LAST);
  assign busy    = (state != IDLE);

`ifdef SEQ_SERIALIZER_PARITY_EN
  logic parityBit;
  assign data_ready = !rst && ((state == IDLE) || (state == PAR));
`else
  assign data_ready = !rst && ((state == IDLE) || lastBit);
`endif

  assign accept = data_valid && data_ready;

  // accept can only occur in IDLE, PAR or on the last data bit, so it takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitCnt      <= '0;
      shiftReg    <= '0;
      seq_out     <= IDLE_LEVEL;
      seq_valid   <= 1'b0;
      frame_start <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parityBit   <= 1'b0;
`endif
    end else if (accept) begin
      state       <= SHIFT;
      bitCnt      <= '0;
      shiftReg    <= shiftOnce(data_in);
      seq_out     <= headBit(data_in);
      seq_valid   <= 1'b1;
      frame_start <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parityBit   <= ^data_in;
`endif
    end else begin
      frame_start <= 1'b0;
      if (state == SHIFT && !lastBit) begin
        bitCnt    <= bitCnt + CNT_W'(1);
        shiftReg  <= shiftOnce(shiftReg);
        seq_out   <= headBit(shiftReg);
        seq_valid <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      end else if (lastBit) begin
        state     <= PAR;
        bitCnt    <= '0;
        seq_out   <= parityBit;
        seq_valid <= 1'b1;
`endif
      end else begin
        state     <= IDLE;
        bitCnt    <= '0;
        seq_out   <= IDLE_LEVEL;
        seq_valid <= 1'b0;
      end
    end
  end

endmodule
